// File: rtl/icw_ocw_sequencer.sv
// 8259 command-word controller: sequences ICW1..ICW4 initialization, then decodes
// OCW1/2/3 and holds the configuration registers and one-cycle command pulses.
module icw_ocw_sequencer #(
    parameter logic [7:0] IMR_INIT        = 8'h00,
    parameter bit         OCW_BEFORE_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_flag,
    input  logic       A0,
    input  logic [7:0] data_in,
    output logic       init_done,
    output logic       ICW1_LTIM,
    output logic       ICW1_SNGL,
    output logic [4:0] vector_base,
    output logic [7:0] ICW3_reg,
    output logic       ICW4_AEOI,
    output logic       ICW4_uPM,
    output logic [7:0] OCW1,
    output logic       eoi_nonspecific,
    output logic       eoi_specific,
    output logic [2:0] eoi_level,
    output logic       rotate_on_eoi,
    output logic       set_priority,
    output logic       auto_rotate_status,
    output logic       special_mask_mode,
    output logic       read_isr_select,
    output logic       poll_cmd
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ICW2  = 3'd1,
        S_ICW3  = 3'd2,
        S_ICW4  = 3'd3,
        S_READY = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic       ic4, ic4_nxt;
    logic       init_done_nxt, ltim_nxt, sngl_nxt, aeoi_nxt, upm_nxt;
    logic [4:0] vector_base_nxt;
    logic [7:0] icw3_nxt, ocw1_nxt;
    logic       eoi_ns_nxt, eoi_sp_nxt, rot_nxt, setp_nxt, poll_nxt;
    logic [2:0] eoi_level_nxt;
    logic       arot_nxt, smm_nxt, ris_nxt;
    logic       ocw_ok;
    logic       is_icw1;

    // State and all outputs registered together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            ic4                <= 1'b0;
            init_done          <= 1'b0;
            ICW1_LTIM          <= 1'b0;
            ICW1_SNGL          <= 1'b0;
            vector_base        <= 5'd0;
            ICW3_reg           <= 8'd0;
            ICW4_AEOI          <= 1'b0;
            ICW4_uPM           <= 1'b0;
            OCW1               <= IMR_INIT;
            eoi_nonspecific    <= 1'b0;
            eoi_specific       <= 1'b0;
            eoi_level          <= 3'd0;
            rotate_on_eoi      <= 1'b0;
            set_priority       <= 1'b0;
            auto_rotate_status <= 1'b0;
            special_mask_mode  <= 1'b0;
            read_isr_select    <= 1'b0;
            poll_cmd           <= 1'b0;
        end else begin
            state              <= state_nxt;
            ic4                <= ic4_nxt;
            init_done          <= init_done_nxt;
            ICW1_LTIM          <= ltim_nxt;
            ICW1_SNGL          <= sngl_nxt;
            vector_base        <= vector_base_nxt;
            ICW3_reg           <= icw3_nxt;
            ICW4_AEOI          <= aeoi_nxt;
            ICW4_uPM           <= upm_nxt;
            OCW1               <= ocw1_nxt;
            eoi_nonspecific    <= eoi_ns_nxt;
            eoi_specific       <= eoi_sp_nxt;
            eoi_level          <= eoi_level_nxt;
            rotate_on_eoi      <= rot_nxt;
            set_priority       <= setp_nxt;
            auto_rotate_status <= arot_nxt;
            special_mask_mode  <= smm_nxt;
            read_isr_select    <= ris_nxt;
            poll_cmd           <= poll_nxt;
        end
    end

    // Write decode and sequencing; levels hold, pulses default low
    always_comb begin
        state_nxt       = state;
        ic4_nxt         = ic4;
        ltim_nxt        = ICW1_LTIM;
        sngl_nxt        = ICW1_SNGL;
        vector_base_nxt = vector_base;
        icw3_nxt        = ICW3_reg;
        aeoi_nxt        = ICW4_AEOI;
        upm_nxt         = ICW4_uPM;
        ocw1_nxt        = OCW1;
        eoi_level_nxt   = eoi_level;
        arot_nxt        = auto_rotate_status;
        smm_nxt         = special_mask_mode;
        ris_nxt         = read_isr_select;
        eoi_ns_nxt      = 1'b0;
        eoi_sp_nxt      = 1'b0;
        rot_nxt         = 1'b0;
        setp_nxt        = 1'b0;
        poll_nxt        = 1'b0;
        is_icw1         = write_flag && !A0 && data_in[4];
        ocw_ok          = (state == S_READY) || ((state == S_IDLE) && OCW_BEFORE_INIT);

        case (state)
            S_IDLE, S_ICW2, S_ICW3, S_ICW4, S_READY: ;
            default: state_nxt = S_IDLE;
        endcase

        if (is_icw1) begin
            ltim_nxt      = data_in[3];
            sngl_nxt      = data_in[1];
            ic4_nxt       = data_in[0];
            ocw1_nxt      = IMR_INIT;
            icw3_nxt      = 8'd0;
            aeoi_nxt      = 1'b0;
            upm_nxt       = 1'b0;
            arot_nxt      = 1'b0;
            smm_nxt       = 1'b0;
            ris_nxt       = 1'b0;
            eoi_level_nxt = 3'd0;
            state_nxt     = S_ICW2;
        end else if (write_flag && A0) begin
            case (state)
                S_ICW2: begin
                    vector_base_nxt = data_in[7:3];
                    if (!ICW1_SNGL) state_nxt = S_ICW3;
                    else if (ic4)   state_nxt = S_ICW4;
                    else            state_nxt = S_READY;
                end
                S_ICW3: begin
                    icw3_nxt  = data_in;
                    state_nxt = ic4 ? S_ICW4 : S_READY;
                end
                S_ICW4: begin
                    upm_nxt   = data_in[0];
                    aeoi_nxt  = data_in[1];
                    state_nxt = S_READY;
                end
                default: if (ocw_ok) ocw1_nxt = data_in;
            endcase
        end else if (write_flag && ocw_ok) begin
            if (data_in[3]) begin
                if (data_in[6]) smm_nxt = data_in[5];
                if (data_in[2])      poll_nxt = 1'b1;
                else if (data_in[1]) ris_nxt  = data_in[0];
            end else begin
                eoi_level_nxt = data_in[2:0];
                case (data_in[7:5])
                    3'b001: eoi_ns_nxt = 1'b1;
                    3'b011: eoi_sp_nxt = 1'b1;
                    3'b101: begin eoi_ns_nxt = 1'b1; rot_nxt = 1'b1; end
                    3'b111: begin eoi_sp_nxt = 1'b1; rot_nxt = 1'b1; end
                    3'b100: arot_nxt = 1'b1;
                    3'b000: arot_nxt = 1'b0;
                    3'b110: setp_nxt = 1'b1;
                    default: ;
                endcase
            end
        end

        init_done_nxt = (state_nxt == S_READY);
    end

endmodule

// File: tb/tb_icw_ocw_sequencer.sv
// Directed bench for icw_ocw_sequencer: a behavioural model pushes the expected
// output vector per cycle into a scoreboard queue, popped after each clock edge.
module tb_icw_ocw_sequencer;

    localparam logic [7:0] IMR_INIT = 8'h00;

    typedef struct packed {
        logic       init_done;
        logic       ltim;
        logic       sngl;
        logic [4:0] vb;
        logic [7:0] icw3;
        logic       aeoi;
        logic       upm;
        logic [7:0] ocw1;
        logic       eoi_ns;
        logic       eoi_sp;
        logic [2:0] lvl;
        logic       rot;
        logic       setp;
        logic       arot;
        logic       smm;
        logic       ris;
        logic       poll;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       write_flag = 1'b0;
    logic       A0 = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       init_done, ICW1_LTIM, ICW1_SNGL, ICW4_AEOI, ICW4_uPM;
    logic [4:0] vector_base;
    logic [7:0] ICW3_reg, OCW1;
    logic       eoi_nonspecific, eoi_specific, rotate_on_eoi, set_priority;
    logic [2:0] eoi_level;
    logic       auto_rotate_status, special_mask_mode, read_isr_select, poll_cmd;

    int checks = 0;
    int errors = 0;

    out_t m;
    int   ms;
    logic mic4;
    out_t sbq[$];

    icw_ocw_sequencer #(.IMR_INIT(IMR_INIT), .OCW_BEFORE_INIT(1'b0)) dut (
        .clk(clk), .reset(reset), .write_flag(write_flag), .A0(A0), .data_in(data_in),
        .init_done(init_done), .ICW1_LTIM(ICW1_LTIM), .ICW1_SNGL(ICW1_SNGL),
        .vector_base(vector_base), .ICW3_reg(ICW3_reg), .ICW4_AEOI(ICW4_AEOI),
        .ICW4_uPM(ICW4_uPM), .OCW1(OCW1), .eoi_nonspecific(eoi_nonspecific),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level), .rotate_on_eoi(rotate_on_eoi),
        .set_priority(set_priority), .auto_rotate_status(auto_rotate_status),
        .special_mask_mode(special_mask_mode), .read_isr_select(read_isr_select),
        .poll_cmd(poll_cmd)
    );

    always #5 clk = ~clk;

    function automatic out_t observed();
        out_t o;
        o.init_done = init_done;   o.ltim = ICW1_LTIM;     o.sngl = ICW1_SNGL;
        o.vb = vector_base;        o.icw3 = ICW3_reg;      o.aeoi = ICW4_AEOI;
        o.upm = ICW4_uPM;          o.ocw1 = OCW1;          o.eoi_ns = eoi_nonspecific;
        o.eoi_sp = eoi_specific;   o.lvl = eoi_level;      o.rot = rotate_on_eoi;
        o.setp = set_priority;     o.arot = auto_rotate_status;
        o.smm = special_mask_mode; o.ris = read_isr_select; o.poll = poll_cmd;
        return o;
    endfunction

    task automatic model_reset();
        m = '0;
        m.ocw1 = IMR_INIT;
        ms = 0;
        mic4 = 1'b0;
    endtask

    // Reference behaviour: ms 0=idle 1=icw2 2=icw3 3=icw4 4=ready
    task automatic model_step(input logic wf, input logic a0, input logic [7:0] d);
        m.eoi_ns = 0; m.eoi_sp = 0; m.rot = 0; m.setp = 0; m.poll = 0;
        if (wf) begin
            if (!a0 && d[4]) begin
                m.ltim = d[3]; m.sngl = d[1]; mic4 = d[0];
                m.ocw1 = IMR_INIT; m.icw3 = 8'h00; m.aeoi = 0; m.upm = 0;
                m.arot = 0; m.smm = 0; m.ris = 0; m.lvl = 3'd0;
                ms = 1;
            end else if (a0) begin
                if (ms == 1) begin
                    m.vb = d[7:3];
                    ms = (m.sngl == 1'b0) ? 2 : (mic4 ? 3 : 4);
                end else if (ms == 2) begin
                    m.icw3 = d;
                    ms = mic4 ? 3 : 4;
                end else if (ms == 3) begin
                    m.upm = d[0]; m.aeoi = d[1];
                    ms = 4;
                end else if (ms == 4) begin
                    m.ocw1 = d;
                end
            end else if (ms == 4) begin
                if (d[3]) begin
                    if (d[6]) m.smm = d[5];
                    if (d[2]) m.poll = 1;
                    else if (d[1]) m.ris = d[0];
                end else begin
                    m.lvl = d[2:0];
                    m.eoi_ns = (d[7:5] == 3'b001) || (d[7:5] == 3'b101);
                    m.eoi_sp = (d[7:5] == 3'b011) || (d[7:5] == 3'b111);
                    m.rot    = d[7] && d[5];
                    m.setp   = (d[7:5] == 3'b110);
                    if (d[7:5] == 3'b100) m.arot = 1;
                    if (d[7:5] == 3'b000) m.arot = 0;
                end
            end
        end
        m.init_done = (ms == 4);
    endtask

    task automatic chk_vec(input string tag);
        out_t exp_v, got_v;
        exp_v = sbq.pop_front();
        got_v = observed();
        checks++;
        assert (got_v === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got_v, exp_v);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input string tag, input logic wf, input logic a0, input logic [7:0] d);
        @(negedge clk);
        write_flag = wf; A0 = a0; data_in = d;
        model_step(wf, a0, d);
        sbq.push_back(m);
        @(posedge clk);
        #1;
        write_flag = 1'b0;
        chk_vec(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        write_flag = 1'b0;
        #1;
        model_reset();
        sbq.push_back(m);
        chk_vec(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        do_reset("reset");
        chk("reset_ocw1", 32'(OCW1), 32'(IMR_INIT));
        step("idle_ocw1_ignored", 1, 1, 8'hFF);
        step("idle_ocw2_ignored", 1, 0, 8'h20);

        // Single, ICW4 needed
        step("s_icw1", 1, 0, 8'h13);
        step("s_icw2", 1, 1, 8'h20);
        chk("s_not_done_yet", 32'(init_done), 32'd0);
        step("s_icw4", 1, 1, 8'h03);
        chk("s_vb", 32'(vector_base), 32'h04);
        chk("s_done", 32'({init_done, ICW1_SNGL, ICW4_AEOI, ICW4_uPM}), 32'hF);
        step("s_idle", 0, 0, 8'h00);

        // Cascade with ICW3
        step("c_icw1", 1, 0, 8'h11);
        step("c_icw2", 1, 1, 8'h40);
        step("c_icw3", 1, 1, 8'h04);
        step("c_ocw2_in_icw4", 1, 0, 8'h20);
        step("c_icw4", 1, 1, 8'h01);
        chk("c_icw3_reg", 32'(ICW3_reg), 32'h04);
        chk("c_done", 32'(init_done), 32'd1);

        // Restart mid-init
        step("r_icw1", 1, 0, 8'h11);
        step("r_icw2", 1, 1, 8'h40);
        step("r_ocw2_in_icw3", 1, 0, 8'h20);
        chk("r_no_pulse", 32'(eoi_nonspecific), 32'd0);
        step("r_icw1_again", 1, 0, 8'h1A);
        chk("r_ltim", 32'(ICW1_LTIM), 32'd1);
        step("r_icw2_ready", 1, 1, 8'h08);
        chk("r_icw4_zero", 32'({init_done, ICW4_AEOI, ICW4_uPM}), 32'h4);

        // Operation commands
        step("ocw1_a5", 1, 1, 8'hA5);
        chk("ocw1_val", 32'(OCW1), 32'hA5);
        step("ocw2_spec", 1, 0, 8'h63);
        chk("spec_lvl", 32'({eoi_specific, eoi_level}), 32'hB);
        step("spec_clear", 0, 0, 8'h00);
        step("ocw2_ns_rot", 1, 0, 8'hA0);
        chk("ns_rot", 32'({eoi_nonspecific, rotate_on_eoi}), 32'h3);
        step("ocw2_arot_on", 1, 0, 8'h80);
        chk("arot_on", 32'(auto_rotate_status), 32'd1);
        step("ocw2_arot_off", 1, 0, 8'h00);
        step("ocw2_spec_rot", 1, 0, 8'hE2);
        step("ocw2_nop", 1, 0, 8'h41);
        step("ocw2_setp", 1, 0, 8'hC6);
        chk("setp", 32'({set_priority, eoi_level}), 32'hE);
        step("ocw3_ris", 1, 0, 8'h0B);
        step("ocw3_smm", 1, 0, 8'h68);
        chk("smm", 32'(special_mask_mode), 32'd1);
        step("ocw3_poll", 1, 0, 8'h0C);
        chk("poll_ris", 32'({poll_cmd, read_isr_select}), 32'h3);
        step("poll_clear", 0, 0, 8'h00);
        step("ocw3_irr", 1, 0, 8'h4A);

        // Reset asserted during S_ICW4
        step("x_icw1", 1, 0, 8'h13);
        step("x_icw2", 1, 1, 8'h20);
        do_reset("reset_in_icw4");
        chk("x_ocw1", 32'(OCW1), 32'(IMR_INIT));
        step("x_after", 0, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
